ahb_slave_ctrl: RTL and testbench
=================================

# ahb_slave_ctrl

AHB-Lite slave (responder) front end of the AHB-to-SPI bridge. Accepts AHB-Lite address/data phases from the master, checks size/alignment, and converts each valid NONSEQ/SEQ beat into a single req/ack transaction toward the SPI-side datapath. It inserts wait states until the downstream side acknowledges, then returns read data or a two-cycle ERROR response.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (HSIZE up to word)
- TIMEOUT_CYCLES, 255, downstream ack timeout; used only with AHB_SLV_TIMEOUT_EN
- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  ADDR_W  address-phase address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word
- HWDATA  in  DATA_W  data-phase write data
- HREADY  in  1  bus-level ready (previous transfer complete)
- HRDATA  out  DATA_W  read data, registered
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- req  out  1  downstream request, level, held until ack
- req_write, req_size[2:0], req_addr[ADDR_W-1:0]  out  registered copies of the captured address phase
- req_wdata  out  DATA_W  HWDATA pass-through; valid while req=1
- ack  in  1  downstream completion, one-cycle pulse
- ack_err  in  1  qualifies ack as failed
- rdata  in  DATA_W  read data, valid with ack

## Operation
- Address phase is sampled when HSEL & HREADY & HTRANS[1]. Otherwise nothing is captured.
- IDLE/BUSY, or not selected: OKAY response, zero wait, no req.
- Illegal beat: HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
  - No req is issued.
  - Slave goes to ERR1.
- FSM states: IDLE, ACCESS, DONE, ERR1, ERR2.
- IDLE --valid--> ACCESS; IDLE --illegal--> ERR1.
- ACCESS: req=1, HREADYOUT=0.
  - ack & !ack_err goes to DONE.
  - ack & ack_err goes to ERR1.
- DONE: HREADYOUT=1, HRESP=0.
  - HRDATA holds rdata latched on ack for reads; writes leave HRDATA unchanged.
  - A new address phase may be sampled here, enabling back-to-back bursts. Next state is ACCESS, ERR1 or IDLE.
- ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
- ERR2: HREADYOUT=1, HRESP=1. The address phase is sampled as in DONE. If the master cancels to IDLE, the next state is IDLE.
- ack while not in ACCESS is ignored. ack_err without ack is ignored.
- HWRITE and HSIZE of SEQ beats are taken per beat. No burst length or type tracking is done; the master controls bursts.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, req=0, req_addr=0, req_write=0, req_size=0. State is IDLE.
- Reset mid-ACCESS: req drops at the next edge and no response completes. The downstream side must abandon the transaction.
- Valid beat sampled at edge T gives req=1 from T+1. The minimum data phase is 2 cycles (ACCESS then DONE).
- ack at cycle k gives HREADYOUT=1 and HRDATA valid in cycle k+1. req=0 in cycle k+1 unless a new beat was sampled.
- A burst of N beats with ack in the first ACCESS cycle completes in 2N cycles.
- The error response is always exactly 2 cycles.
- req_addr, req_write and req_size stay stable for the whole ACCESS state.

## Configuration
- AHB_SLV_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments every ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES with no ack, req drops and the FSM goes to ERR1.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- AHB_SLV_TIMEOUT_EN undefined: no counter exists and ACCESS waits indefinitely for ack.

## Structure
- Shared package ahb_lite_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE encodings
  - HRESP OKAY/ERROR
  - the slave state enum
- One sub-module, ahb_slv_addr_check: combinational size/alignment check producing legal from HADDR[1:0] and HSIZE.

## Test plan
- Single word write to 0x0000_0010 with data 0xDEADBEEF, ack 3 cycles after req → req_addr=0x10, req_write=1, req_wdata=0xDEADBEEF; HREADYOUT low 3 cycles then high with HRESP=0.
- INCR4 read from 0x20, ack in the first ACCESS cycle returning 0x11/0x22/0x33/0x44 → HRDATA sequence 0x11, 0x22, 0x33, 0x44; 8 cycles total; req_addr 0x20, 0x24, 0x28, 0x2C.
- Word access at 0x02 → no req; HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; then OKAY IDLE.
- ack with ack_err=1 on a read → two-cycle ERROR response; HRDATA unchanged.
- BUSY inserted mid-burst, plus HSEL=0 traffic → zero-wait OKAY, no req pulses.
- With AHB_SLV_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never asserted → req high exactly 4 cycles, then ERROR response. Separately, HRESET pulsed mid-ACCESS → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-Lite encodings and slave state constants
package ahb_lite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    typedef logic [2:0] slv_state_t;
    localparam slv_state_t ST_IDLE   = 3'd0;
    localparam slv_state_t ST_ACCESS = 3'd1;
    localparam slv_state_t ST_DONE   = 3'd2;
    localparam slv_state_t ST_ERR1   = 3'd3;
    localparam slv_state_t ST_ERR2   = 3'd4;
endpackage

// File: rtl/ahb_slv_addr_check.sv
// ahb_slv_addr_check: flags a beat legal when HSIZE is at most a word and the address is naturally aligned
import ahb_lite_pkg::*;
module ahb_slv_addr_check (
    input  logic [1:0] addr_lo,
    input  logic [2:0] size,
    output logic       legal
);
    assign legal = (size == HSIZE_BYTE) ||
                   (size == HSIZE_HALF && !addr_lo[0]) ||
                   (size == HSIZE_WORD && addr_lo == 2'b00);
endmodule

// File: rtl/ahb_slave_ctrl.sv
// ahb_slave_ctrl: AHB-Lite responder turning each beat into a req/ack transaction; AHB_SLV_TIMEOUT_EN adds an ack timeout
import ahb_lite_pkg::*;
module ahb_slave_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic              req,
    output logic              req_write,
    output logic [2:0]        req_size,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              ack,
    input  logic              ack_err,
    input  logic [DATA_W-1:0] rdata
);
    slv_state_t state, state_nxt;
    logic legal, sample, timeout;
    ahb_slv_addr_check u_chk (
        .addr_lo(HADDR[1:0]),
        .size   (HSIZE),
        .legal  (legal)
    );
    assign HREADYOUT = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
    assign HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign req       = (state == ST_ACCESS);
    assign req_wdata = HWDATA;
    assign sample    = HREADYOUT && HSEL && HREADY &&
                       (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
`ifdef AHB_SLV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    // count ACCESS cycles, restarting from zero on every entry
    always_ff @(posedge HCLK) begin
        if (HRESET || state != ST_ACCESS) cnt <= '0;
        else                               cnt <= cnt + 1'b1;
    end
    assign timeout = req && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif
    // next state: ACCESS waits for ack, error response is always ERR1 then ERR2
    always_comb begin
        state_nxt = (state == ST_ACCESS) ? (ack ? (ack_err ? ST_ERR1 : ST_DONE) : (timeout ? ST_ERR1 : ST_ACCESS)) :
                    (state == ST_ERR1)   ? ST_ERR2 :
                    sample               ? (legal ? ST_ACCESS : ST_ERR1) : ST_IDLE;
    end
    // state, captured address phase and read data
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            req_write <= 1'b0;
            req_size  <= 3'd0;
            HRDATA    <= '0;
        end else begin
            state <= state_nxt;
            if (sample && legal) begin
                req_addr  <= HADDR;
                req_write <= HWRITE;
                req_size  <= HSIZE;
            end
            if (req && ack && !ack_err && !req_write) HRDATA <= rdata;
        end
    end
endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// tb_ahb_slave_ctrl: directed self-checking bench for ahb_slave_ctrl
`timescale 1ns/1ps
module tb_ahb_slave_ctrl;
    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA, req_addr, req_wdata, rdata;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, req_size;
    logic        req, req_write, ack, ack_err;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0, n;

    ahb_slave_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .req(req),
        .req_write(req_write), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .ack_err(ack_err), .rdata(rdata)
    );

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic addr_ph(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] s);
        HTRANS = tr;
        HADDR  = a;
        HWRITE = w;
        HSIZE  = s;
    endtask

    task automatic err_resp(input string tag);
        chk({tag, "_e1_rdy"}, 32'(HREADYOUT), 0);
        chk({tag, "_e1_resp"}, 32'(HRESP), 1);
        chk({tag, "_e1_req"}, 32'(req), 0);
        step();
        chk({tag, "_e2_rdy"}, 32'(HREADYOUT), 1);
        chk({tag, "_e2_resp"}, 32'(HRESP), 1);
        step();
        chk({tag, "_idle_rdy"}, 32'(HREADYOUT), 1);
        chk({tag, "_idle_resp"}, 32'(HRESP), 0);
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HWDATA = '0; ack = 1'b0; ack_err = 1'b0; rdata = '0;
        addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
        step();
        step();
        HRESET = 1'b0;
        chk("rst_hreadyout", 32'(HREADYOUT), 1);
        chk("rst_hresp", 32'(HRESP), 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_write", 32'(req_write), 0);
        chk("rst_req_size", 32'(req_size), 0);

        // single word write, ack in third ACCESS cycle
        HSEL = 1'b1;
        addr_ph(2'b10, 32'h10, 1'b1, 3'd2);
        step();
        addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
        HWDATA = 32'hDEADBEEF;
        chk("wr_req", 32'(req), 1);
        chk("wr_req_addr", req_addr, 32'h10);
        chk("wr_req_write", 32'(req_write), 1);
        chk("wr_req_size", 32'(req_size), 2);
        chk("wr_req_wdata", req_wdata, 32'hDEADBEEF);
        chk("wr_wait1", 32'(HREADYOUT), 0);
        step();
        chk("wr_wait2", 32'(HREADYOUT), 0);
        step();
        chk("wr_wait3", 32'(HREADYOUT), 0);
        chk("wr_addr_stable", req_addr, 32'h10);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("wr_done_rdy", 32'(HREADYOUT), 1);
        chk("wr_done_resp", 32'(HRESP), 0);
        chk("wr_done_req", 32'(req), 0);
        chk("wr_hrdata_kept", HRDATA, 0);
        step();

        // INCR4 read from 0x20, ack in first ACCESS cycle
        addr_ph(2'b10, 32'h20, 1'b0, 3'd2);
        step();
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            chk("burst_req", 32'(req), 1);
            chk("burst_req_addr", req_addr, 32'h20 + 32'(4 * i));
            if (i < 3) addr_ph(2'b11, 32'h24 + 32'(4 * i), 1'b0, 3'd2);
            else       addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
            ack = 1'b1;
            rdata = 32'h11 * 32'(i + 1);
            step();
            ack = 1'b0;
            chk("burst_rdy", 32'(HREADYOUT), 1);
            chk("burst_hrdata", HRDATA, 32'h11 * 32'(i + 1));
            if (i < 3) step();
        end
        chk("burst_cycles", 32'(cyc - t0 + 1), 8);
        step();

        // misaligned word, misaligned half, oversized beat
        addr_ph(2'b10, 32'h02, 1'b0, 3'd2);
        step();
        addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
        err_resp("word_at_2");
        addr_ph(2'b10, 32'h01, 1'b1, 3'd1);
        step();
        addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
        err_resp("half_at_1");
        addr_ph(2'b10, 32'h00, 1'b0, 3'd3);
        step();
        addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
        err_resp("size3");

        // aligned halfword read
        addr_ph(2'b10, 32'h02, 1'b0, 3'd1);
        step();
        addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
        chk("half_req", 32'(req), 1);
        chk("half_req_size", 32'(req_size), 1);
        ack = 1'b1; rdata = 32'hABCD;
        step();
        ack = 1'b0;
        chk("half_hrdata", HRDATA, 32'hABCD);
        step();

        // read acked with error
        addr_ph(2'b10, 32'h30, 1'b0, 3'd2);
        step();
        addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
        ack = 1'b1; ack_err = 1'b1; rdata = 32'h99;
        step();
        ack = 1'b0; ack_err = 1'b0;
        chk("ackerr_hrdata", HRDATA, 32'hABCD);
        err_resp("ackerr");

        // unselected, BUSY and stray ack traffic
        HSEL = 1'b0;
        addr_ph(2'b10, 32'h40, 1'b0, 3'd2);
        step();
        chk("nosel_req", 32'(req), 0);
        chk("nosel_rdy", 32'(HREADYOUT), 1);
        HSEL = 1'b1;
        addr_ph(2'b01, 32'h40, 1'b0, 3'd2);
        ack = 1'b1; rdata = 32'h55;
        step();
        ack = 1'b0;
        chk("busy_req", 32'(req), 0);
        chk("busy_rdy", 32'(HREADYOUT), 1);
        chk("stray_ack_hrdata", HRDATA, 32'hABCD);
        addr_ph(2'b10, 32'h50, 1'b0, 3'd2);
        step();
        addr_ph(2'b01, 32'h54, 1'b0, 3'd2);
        ack = 1'b1; rdata = 32'h66;
        step();
        ack = 1'b0;
        chk("bb_beat0", HRDATA, 32'h66);
        step();
        chk("bb_busy_req", 32'(req), 0);
        chk("bb_busy_rdy", 32'(HREADYOUT), 1);
        addr_ph(2'b11, 32'h54, 1'b0, 3'd2);
        step();
        addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
        chk("bb_seq_addr", req_addr, 32'h54);
        ack = 1'b1; rdata = 32'h77;
        step();
        ack = 1'b0;
        chk("bb_beat1", HRDATA, 32'h77);
        step();

        // no ack: timeout after 4 cycles, or indefinite wait
        addr_ph(2'b10, 32'h60, 1'b1, 3'd2);
        step();
        addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
        n = 0;
        while (req && n < 10) begin
            n++;
            step();
        end
`ifdef AHB_SLV_TIMEOUT_EN
        chk("to_req_cycles", 32'(n), 4);
        err_resp("timeout");
`else
        chk("noto_req_cycles", 32'(n), 10);
        chk("noto_wait", 32'(HREADYOUT), 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("noto_done", 32'(HREADYOUT), 1);
        step();
`endif

        // reset during ACCESS
        addr_ph(2'b10, 32'h70, 1'b1, 3'd2);
        step();
        addr_ph(2'b00, 32'h0, 1'b0, 3'd0);
        chk("mid_req", 32'(req), 1);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        chk("mid_rst_req", 32'(req), 0);
        chk("mid_rst_rdy", 32'(HREADYOUT), 1);
        chk("mid_rst_resp", 32'(HRESP), 0);
        chk("mid_rst_hrdata", HRDATA, 0);
        chk("mid_rst_addr", req_addr, 0);
        chk("mid_rst_write", 32'(req_write), 0);
        chk("mid_rst_size", 32'(req_size), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
